// File: rtl/sd_ctrl_pkg.sv
// sd_ctrl_pkg: shared FSM state and mode types for the scandoubler mode controller.
package sd_ctrl_pkg;
  typedef enum logic [1:0] {UNLOCK, APPLY, MUTE, LOCK} state_t;
  typedef struct packed {
    logic sd_en;
    logic hq2x;
  } mode_t;
endpackage

// File: rtl/sd_timing_meas.sv
// sd_timing_meas: samples raw sync on ce_pix and measures line/frame length with saturating counters.
module sd_timing_meas #(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11
) (
  input  logic              clk_sys_i,
  input  logic              reset_i,
  input  logic              ce_pix_i,
  input  logic              hs_i,
  input  logic              vs_i,
  output logic              frame_start_o,
  output logic              invalid_o,
  output logic [HCNT_W-1:0] h_meas_o,
  output logic [VCNT_W-1:0] v_meas_o,
  output logic [HCNT_W-1:0] htotal_o,
  output logic [VCNT_W-1:0] vtotal_o
);
  logic hs_q, vs_q, line_start, hsat, vsat;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d, htotal_q, htotal_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d, vtotal_q, vtotal_d;
  assign line_start    = ce_pix_i & hs_i & ~hs_q;
  assign frame_start_o = ce_pix_i & vs_i & ~vs_q;
  assign hsat          = &hcnt_q;
  assign vsat          = &vcnt_q;
  // A stuck counter keeps flagging every sample until the missing edge arrives.
  assign invalid_o     = ce_pix_i & ((hsat & ~line_start) | (vsat & ~frame_start_o));
  // The line just closed by a coincident line start is the frame's last complete line.
  assign h_meas_o      = line_start ? hcnt_q : htotal_q;
  assign v_meas_o      = vcnt_q;
  assign htotal_o      = htotal_q;
  assign vtotal_o      = vtotal_q;
  always_comb begin
    hcnt_d   = line_start ? HCNT_W'(1) : (ce_pix_i & ~hsat) ? hcnt_q + HCNT_W'(1) : hcnt_q;
    htotal_d = line_start ? hcnt_q : (ce_pix_i & hsat) ? '1 : htotal_q;
    vcnt_d   = frame_start_o ? VCNT_W'(line_start) : (line_start & ~vsat) ? vcnt_q + VCNT_W'(1) : vcnt_q;
    vtotal_d = frame_start_o ? vcnt_q : vtotal_q;
  end
  always_ff @(posedge clk_sys_i or posedge reset_i)
    if (reset_i) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      htotal_q <= '0;
      vtotal_q <= '0;
    end else begin
      hs_q     <= ce_pix_i ? hs_i : hs_q;
      vs_q     <= ce_pix_i ? vs_i : vs_q;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      htotal_q <= htotal_d;
      vtotal_q <= vtotal_d;
    end
endmodule

// File: rtl/sd_mode_ctrl.sv
// sd_mode_ctrl: locks onto stable raw video timing and switches doubler/HQ2x only at frame boundaries.
// Define SDCTRL_INTERLACE_EN to accept alternating +/-1 line frames and add the interlaced output.
module sd_mode_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int HCNT_W        = 12,
  parameter int VCNT_W        = 11,
  parameter int STABLE_FRAMES = 4,
  parameter int MUTE_FRAMES   = 2,
  parameter int LINE_THRESH   = 400
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              hb_in,
  input  logic              vb_in,
  input  logic              user_sd_en,
  input  logic              user_hq2x,
  output logic              sd_en,
  output logic              hq2x,
  output logic              mute,
  output logic              locked,
  output logic [HCNT_W-1:0] htotal,
`ifdef SDCTRL_INTERLACE_EN
  output logic [VCNT_W-1:0] vtotal,
  output logic              interlaced
`else
  output logic [VCNT_W-1:0] vtotal
`endif
);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int UW = $clog2(MUTE_FRAMES + 1);
  state_t state_q, state_d;
  mode_t mode_q, mode_d, user_q, user_d, user_now, new_mode;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [UW-1:0] ucnt_q, ucnt_d;
  logic [HCNT_W-1:0] h_meas, prev_h_q, prev_h_d;
  logic [VCNT_W-1:0] v_meas, prev_v_q, prev_v_d, v_min;
  logic fs, invalid, valid, h_ok, v_eq, v_ok, match, sd_ok, user_chg, unused_blank;
  sd_timing_meas #(.HCNT_W(HCNT_W), .VCNT_W(VCNT_W)) u_meas (
    .clk_sys_i(clk_sys), .reset_i(reset), .ce_pix_i(ce_pix), .hs_i(hs_in), .vs_i(vs_in),
    .frame_start_o(fs), .invalid_o(invalid), .h_meas_o(h_meas), .v_meas_o(v_meas),
    .htotal_o(htotal), .vtotal_o(vtotal)
  );
  assign unused_blank = hb_in | vb_in;
  assign valid = !(&h_meas) && !(&v_meas) && !(&prev_h_q) && !(&prev_v_q);
  assign h_ok  = (h_meas == prev_h_q) || (h_meas == prev_h_q + HCNT_W'(1)) || (h_meas + HCNT_W'(1) == prev_h_q);
  assign v_eq  = v_meas == prev_v_q;
`ifdef SDCTRL_INTERLACE_EN
  logic v_adj, ilace_q, ilace_d;
  assign v_adj      = (v_meas + VCNT_W'(1) == prev_v_q) || (prev_v_q + VCNT_W'(1) == v_meas);
  assign v_ok       = v_eq | v_adj;
  assign v_min      = (v_meas < prev_v_q) ? v_meas : prev_v_q;
  assign ilace_d    = (fs & valid) ? (v_eq ? 1'b0 : v_adj ? 1'b1 : ilace_q) : ilace_q;
  assign interlaced = ilace_q;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) ilace_q <= 1'b0;
    else ilace_q <= ilace_d;
`else
  assign v_ok  = v_eq;
  assign v_min = v_meas;
`endif
  assign match    = valid & h_ok & v_ok;
  assign sd_ok    = user_sd_en & (v_min < VCNT_W'(LINE_THRESH));
  assign new_mode = {sd_ok, sd_ok & user_hq2x};
  assign user_now = {user_sd_en, user_hq2x};
  assign user_chg = user_now != user_q;
  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    ucnt_d   = ucnt_q;
    mode_d   = mode_q;
    user_d   = user_q;
    prev_h_d = fs ? h_meas : prev_h_q;
    prev_v_d = fs ? v_meas : prev_v_q;
    case (state_q)
      UNLOCK: if (fs) begin
        mcnt_d  = (match && mcnt_q != MW'(STABLE_FRAMES - 1)) ? mcnt_q + MW'(1) : '0;
        state_d = (match && mcnt_q == MW'(STABLE_FRAMES - 1)) ? APPLY : UNLOCK;
      end
      APPLY: begin
        state_d = MUTE;
        ucnt_d  = '0;
      end
      MUTE: if (fs) begin
        ucnt_d  = ucnt_q + UW'(1);
        state_d = !match ? UNLOCK : (ucnt_q == UW'(MUTE_FRAMES - 1)) ? LOCK : MUTE;
      end
      default: if (fs) state_d = !match ? UNLOCK : user_chg ? APPLY : LOCK;
    endcase
    if (invalid) begin
      state_d = UNLOCK;
      mcnt_d  = '0;
    end
    // Mode is computed on the frame-start edge so it lands together with APPLY.
    if (state_d == APPLY && state_q != APPLY) begin
      mode_d = new_mode;
      user_d = user_now;
    end
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q  <= UNLOCK;
      mode_q   <= '0;
      user_q   <= '0;
      mcnt_q   <= '0;
      ucnt_q   <= '0;
      prev_h_q <= '1;
      prev_v_q <= '1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      user_q   <= user_d;
      mcnt_q   <= mcnt_d;
      ucnt_q   <= ucnt_d;
      prev_h_q <= prev_h_d;
      prev_v_q <= prev_v_d;
    end
  assign sd_en  = mode_q.sd_en;
  assign hq2x   = mode_q.hq2x;
  assign mute   = state_q != LOCK;
  assign locked = state_q == LOCK;
endmodule

// File: tb/tb_sd_mode_ctrl.sv
// tb_sd_mode_ctrl: directed scaled-down frame sequences with hand-computed lock/mode expectations.
module tb_sd_mode_ctrl;
  logic clk_sys = 1'b0, reset = 1'b1, ce_pix = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic hb_in = 1'b0, vb_in = 1'b0, user_sd_en = 1'b1, user_hq2x = 1'b1;
  logic sd_en, hq2x, mute, locked;
  logic [11:0] htotal;
  logic [10:0] vtotal;
  logic gap = 1'b0;
  logic fs_sd, fs_hq, fs_mute, fs_locked;
  int checks = 0, failures = 0;
`ifdef SDCTRL_INTERLACE_EN
  logic interlaced;
  sd_mode_ctrl dut (.clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in),
    .hb_in(hb_in), .vb_in(vb_in), .user_sd_en(user_sd_en), .user_hq2x(user_hq2x), .sd_en(sd_en),
    .hq2x(hq2x), .mute(mute), .locked(locked), .htotal(htotal), .vtotal(vtotal), .interlaced(interlaced));
`else
  sd_mode_ctrl dut (.clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in),
    .hb_in(hb_in), .vb_in(vb_in), .user_sd_en(user_sd_en), .user_hq2x(user_hq2x), .sd_en(sd_en),
    .hq2x(hq2x), .mute(mute), .locked(locked), .htotal(htotal), .vtotal(vtotal));
`endif
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // One sampled pixel; with gap set, an ignored non-ce cycle carrying sync noise follows.
  task automatic pix(input logic h, input logic v);
    ce_pix = 1'b1;
    hs_in = h;
    vs_in = v;
    @(posedge clk_sys);
    #1;
    if (gap) begin
      ce_pix = 1'b0;
      hs_in = 1'b1;
      vs_in = 1'b1;
      @(posedge clk_sys);
      #1;
    end
  endtask
  task automatic lines(input int h, input int n, input logic first);
    for (int l = 0; l < n; l++)
      for (int p = 0; p < h; p++) begin
        pix(p == 0, first && l == 0 && p == 0);
        if (first && l == 0 && p == 0) begin
          fs_sd = sd_en;
          fs_hq = hq2x;
          fs_mute = mute;
          fs_locked = locked;
        end
      end
  endtask
  task automatic frame(input int h, input int v);
    lines(h, v, 1'b1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    ce_pix = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_sd", sd_en, 0);
    chk("rst_hq", hq2x, 0);
    chk("rst_mute", mute, 1);
    chk("rst_locked", locked, 0);
    chk("rst_htotal", htotal, 0);
    chk("rst_vtotal", vtotal, 0);
    reset = 1'b0;
    // Frame start 1 closes the empty post-reset frame; 2 measures the first full one.
    repeat (2) frame(4, 262);
    chk("a_htotal", htotal, 4);
    chk("a_vtotal", vtotal, 262);
    repeat (3) frame(4, 262);
    chk("a_pre_sd", sd_en, 0);
    chk("a_pre_mute", mute, 1);
    frame(4, 262);
    chk("a_fs6_sd", fs_sd, 1);
    chk("a_fs6_hq", fs_hq, 1);
    chk("a_fs6_mute", fs_mute, 1);
    frame(4, 262);
    chk("a_fs7_locked", locked, 0);
    chk("a_fs7_mute", mute, 1);
    frame(4, 262);
    chk("a_fs8_locked", fs_locked, 1);
    chk("a_fs8_mute", fs_mute, 0);
    frame(4, 264);
    chk("b_fs9_locked", fs_locked, 1);
    frame(4, 262);
    chk("b_fs10_mute", fs_mute, 1);
    chk("b_fs10_locked", fs_locked, 0);
    chk("b_hold_sd", fs_sd, 1);
    chk("b_vtotal", vtotal, 264);
    repeat (6) frame(4, 262);
    chk("b_fs16_locked", locked, 0);
    frame(4, 262);
    chk("b_relock", fs_locked, 1);
    gap = 1'b1;
    lines(4, 131, 1'b1);
    user_hq2x = 1'b0;
    lines(4, 1, 1'b0);
    chk("c_mid_hq", hq2x, 1);
    chk("c_mid_locked", locked, 1);
    lines(4, 130, 1'b0);
    frame(4, 262);
    chk("c_fs19_hq", fs_hq, 0);
    chk("c_fs19_sd", fs_sd, 1);
    chk("c_fs19_mute", fs_mute, 1);
    frame(4, 262);
    chk("c_fs20_mute", fs_mute, 1);
    frame(4, 262);
    chk("c_fs21_locked", fs_locked, 1);
    chk("c_htotal_gap", htotal, 4);
    gap = 1'b0;
    // Last line already holds 4 samples, so the 4092nd low sample hits saturation.
    repeat (4091) pix(1'b0, 1'b0);
    chk("d_pre_locked", locked, 1);
    pix(1'b0, 1'b0);
    chk("d_to_locked", locked, 0);
    chk("d_to_mute", mute, 1);
    chk("d_to_htotal", htotal, 4095);
    chk("d_hold_hq", hq2x, 0);
    do_reset();
    user_hq2x = 1'b1;
    repeat (7) frame(4, 262);
    chk("e_mute_sd", sd_en, 1);
    chk("e_mute_mute", mute, 1);
    reset = 1'b1;
    #1;
    chk("e_arst_sd", sd_en, 0);
    chk("e_arst_hq", hq2x, 0);
    chk("e_arst_mute", mute, 1);
    chk("e_arst_locked", locked, 0);
    chk("e_arst_htotal", htotal, 0);
    chk("e_arst_vtotal", vtotal, 0);
    do_reset();
    repeat (8) frame(2, 525);
    chk("f_locked", locked, 1);
    chk("f_sd", sd_en, 0);
    chk("f_hq", hq2x, 0);
    chk("f_vtotal", vtotal, 525);
    chk("f_htotal", htotal, 2);
    do_reset();
    repeat (8) frame(2, 400);
    chk("t400_locked", locked, 1);
    chk("t400_sd", sd_en, 0);
    do_reset();
    for (int i = 0; i < 10; i++) frame(4, (i % 2 == 1) ? 263 : 262);
    chk("g_vtotal", vtotal, 262);
`ifdef SDCTRL_INTERLACE_EN
    chk("g_locked", locked, 1);
    chk("g_sd", sd_en, 1);
    chk("g_ilace", interlaced, 1);
`else
    chk("g_locked", locked, 0);
    chk("g_mute", mute, 1);
    chk("g_sd", sd_en, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
